// File: rtl/univ_counter.sv
// univ_counter: parameterized up/down binary counter with synchronous clear,
// parallel load, wrap-around or saturating limits, and wrap-event statistics.
module univ_counter #(
  parameter int N   = 8,
  parameter int SAT = 0,
  parameter int WCW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           syn_clr,
  input  logic           load,
  input  logic           en,
  input  logic           up,
  input  logic [N-1:0]   d,
  output logic [N-1:0]   q,
  output logic           max_tick,
  output logic           min_tick,
  output logic           wrap_evt,
  output logic [WCW-1:0] wrap_cnt
);

  localparam logic [N-1:0]   CNT_MAX = {N{1'b1}};
  localparam logic [N-1:0]   CNT_ONE = {{(N-1){1'b0}}, 1'b1};
  localparam logic [WCW-1:0] WC_MAX  = {WCW{1'b1}};
  localparam logic [WCW-1:0] WC_ONE  = {{(WCW-1){1'b0}}, 1'b1};

  logic [N-1:0]   cnt_q,      cnt_d;
  logic           wrap_evt_q, wrap_evt_d;
  logic [WCW-1:0] wrap_cnt_q, wrap_cnt_d;
  logic           limit_hit;

  // Next-state arbitration: clear beats load beats count beats hold.
  always_comb begin
    cnt_d      = cnt_q;
    wrap_cnt_d = wrap_cnt_q;
    wrap_evt_d = 1'b0;
    limit_hit  = 1'b0;
    if (syn_clr) begin
      cnt_d      = '0;
      wrap_cnt_d = '0;
    end else if (load) begin
      cnt_d = d;
    end else if (en) begin
      if (up) begin
        if (cnt_q == CNT_MAX) begin
          limit_hit = 1'b1;
          cnt_d     = (SAT != 0) ? CNT_MAX : '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else begin
        if (cnt_q == '0) begin
          limit_hit = 1'b1;
          cnt_d     = (SAT != 0) ? '0 : CNT_MAX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
    end
    // A limit crossing (or a saturating hit) is one event; the statistic sticks at all-ones.
    if (limit_hit) begin
      wrap_evt_d = 1'b1;
      if (wrap_cnt_q != WC_MAX) begin
        wrap_cnt_d = wrap_cnt_q + WC_ONE;
      end
    end
  end

  // State registers; asynchronous active-low reset clears everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      wrap_evt_q <= 1'b0;
      wrap_cnt_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      wrap_evt_q <= wrap_evt_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  // Output decode: terminal-count flags follow the registered count combinationally.
  always_comb begin
    q        = cnt_q;
    max_tick = (cnt_q == CNT_MAX);
    min_tick = (cnt_q == '0);
    wrap_evt = wrap_evt_q;
    wrap_cnt = wrap_cnt_q;
  end

endmodule

// File: tb/tb_univ_counter.sv
// Bench for univ_counter: a wrap-around instance (SAT=0, WCW=8) and a
// saturating instance (SAT=1, WCW=2) driven in parallel, checked every cycle
// against an arithmetic reference model, plus directed literal expectations.
module tb_univ_counter;
  timeunit 1ns;
  timeprecision 100ps;

  localparam int MAXV = 255;
  localparam int MODV = 256;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       syn_clr = 1'b0, load = 1'b0, en = 1'b0, up = 1'b0;
  logic [7:0] d = 8'h00;

  logic [7:0] q0, q1;
  logic       mx0, mx1, mn0, mn1, ev0, ev1;
  logic [7:0] wc0;
  logic [1:0] wc1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  univ_counter #(.N(8), .SAT(0), .WCW(8)) u_wrap (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q0), .max_tick(mx0), .min_tick(mn0), .wrap_evt(ev0), .wrap_cnt(wc0)
  );

  univ_counter #(.N(8), .SAT(1), .WCW(2)) u_sat (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en), .up(up),
    .d(d), .q(q1), .max_tick(mx1), .min_tick(mn1), .wrap_evt(ev1), .wrap_cnt(wc1)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the count, event flag and event tally.
  int mq[2]    = '{0, 0};
  int mev[2]   = '{0, 0};
  int mwc[2]   = '{0, 0};
  int satp[2]  = '{0, 1};
  int wcmax[2] = '{255, 3};

  always @(posedge clk or negedge reset) begin
    int t;
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        mq[i] = 0; mev[i] = 0; mwc[i] = 0;
      end else if (syn_clr) begin
        mq[i] = 0; mev[i] = 0; mwc[i] = 0;
      end else if (load) begin
        mq[i] = int'(d); mev[i] = 0;
      end else if (en) begin
        t = mq[i] + (up ? 1 : -1);
        if (t < 0 || t > MAXV) begin
          mev[i] = 1;
          if (mwc[i] < wcmax[i]) mwc[i] = mwc[i] + 1;
          if (satp[i] != 0) mq[i] = (t < 0) ? 0 : MAXV;
          else              mq[i] = (t + MODV) % MODV;
        end else begin
          mq[i] = t; mev[i] = 0;
        end
      end else begin
        mev[i] = 0;
      end
    end
  end

  // Every falling edge: compare both instances against the model.
  always @(negedge clk) begin
    chk("q_wrap",    int'(q0),  mq[0]);
    chk("max_wrap",  int'(mx0), int'(mq[0] == MAXV));
    chk("min_wrap",  int'(mn0), int'(mq[0] == 0));
    chk("evt_wrap",  int'(ev0), mev[0]);
    chk("cnt_wrap",  int'(wc0), mwc[0]);
    chk("q_sat",     int'(q1),  mq[1]);
    chk("max_sat",   int'(mx1), int'(mq[1] == MAXV));
    chk("min_sat",   int'(mn1), int'(mq[1] == 0));
    chk("evt_sat",   int'(ev1), mev[1]);
    chk("cnt_sat",   int'(wc1), mwc[1]);
  end

  // Apply one input set for n rising edges; returns just after a falling edge.
  task automatic cyc(input logic c, input logic l, input logic e, input logic u,
                     input logic [7:0] dv, input int n);
    syn_clr = c; load = l; en = e; up = u; d = dv;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int pulse;
    #1;
    chk("lit_rst_q",   int'(q0),  0);
    chk("lit_rst_min", int'(mn0), 1);
    chk("lit_rst_max", int'(mx0), 0);
    chk("lit_rst_evt", int'(ev0), 0);
    chk("lit_rst_cnt", int'(wc0), 0);
    @(negedge clk);
    reset = 1'b1;

    cyc(0, 0, 1, 1, 8'h00, 12);
    chk("lit_up12",     int'(q0),  12);
    chk("lit_up12_min", int'(mn0), 0);
    cyc(0, 0, 1, 0, 8'h00, 6);
    chk("lit_dn6", int'(q0), 6);
    cyc(0, 1, 1, 1, 8'h03, 1);
    chk("lit_load3", int'(q0), 3);
    cyc(0, 0, 1, 1, 8'h00, 2);
    chk("lit_up2", int'(q0), 5);
    cyc(1, 1, 1, 1, 8'hAA, 1);
    chk("lit_clr_q",   int'(q0),  0);
    chk("lit_clr_cnt", int'(wc0), 0);
    cyc(0, 0, 1, 1, 8'h00, 3);
    chk("lit_up3", int'(q0), 3);

    cyc(0, 0, 0, 1, 8'h00, 0);
    #0.5 reset = 1'b0;
    #1;
    chk("lit_async_q",   int'(q0),  0);
    chk("lit_async_min", int'(mn0), 1);
    #1.5 reset = 1'b1;
    @(negedge clk);
    chk("lit_after_rst", int'(q0), 0);
    cyc(0, 0, 1, 1, 8'h00, 5);
    chk("lit_up5", int'(q0), 5);

    cyc(0, 1, 0, 0, 8'hFE, 1);
    cyc(0, 0, 1, 1, 8'h00, 1);
    chk("lit_w_ff",   int'(q0),  8'hFF);
    chk("lit_w_max",  int'(mx0), 1);
    chk("lit_w_evt0", int'(ev0), 0);
    cyc(0, 0, 1, 1, 8'h00, 1);
    chk("lit_w_00",   int'(q0),  0);
    chk("lit_w_evt1", int'(ev0), 1);
    chk("lit_w_cnt1", int'(wc0), 1);
    cyc(0, 0, 1, 1, 8'h00, 1);
    chk("lit_w_01",   int'(q0),  1);
    chk("lit_w_evt2", int'(ev0), 0);
    cyc(0, 1, 0, 0, 8'h00, 1);
    cyc(0, 0, 1, 0, 8'h00, 1);
    chk("lit_w_dn_ff", int'(q0),  8'hFF);
    chk("lit_w_cnt2",  int'(wc0), 2);
    chk("lit_w_evt3",  int'(ev0), 1);

    cyc(1, 0, 0, 0, 8'h00, 1);
    cyc(0, 1, 0, 0, 8'hFE, 1);
    for (int k = 1; k <= 4; k++) begin
      cyc(0, 0, 1, 1, 8'h00, 1);
      chk("lit_s_q",   int'(q1),  8'hFF);
      chk("lit_s_evt", int'(ev1), int'(k >= 2));
    end
    chk("lit_s_cnt3", int'(wc1), 3);
    cyc(0, 0, 1, 1, 8'h00, 2);
    chk("lit_s_stick", int'(wc1), 3);
    chk("lit_s_evt_hold", int'(ev1), 1);

    for (int n = 0; n < 4000; n++) begin
      syn_clr = ($urandom_range(0, 99) < 2);
      load    = ($urandom_range(0, 99) < 8);
      en      = ($urandom_range(0, 99) < 85);
      if ($urandom_range(0, 99) < 8) up = ~up;
      case ($urandom_range(0, 4))
        0:       d = 8'hFE;
        1:       d = 8'h01;
        2:       d = 8'hFF;
        3:       d = 8'h00;
        default: d = 8'($urandom_range(0, 255));
      endcase
      pulse = (($urandom_range(0, 99) < 2) ? 1 : 0);
      if (pulse != 0) begin
        #1 reset = 1'b0;
        #2 reset = 1'b1;
      end
      @(negedge clk);
    end

    cyc(0, 0, 0, 0, 8'h00, 2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
